// File: rtl/play_rate_ctrl_if.sv
// Control/data bundle between the playback sequencer and its host.
// Input names are the ones the sequencer sees; outputs are the ones it drives.
interface play_rate_ctrl_if #(
    parameter int ADDR_W = 20
);
    logic              i_start;
    logic              i_pause;
    logic              i_stop;
    logic              i_speed_up;
    logic              i_speed_down;
    logic              i_mode_fast;
    logic              i_sample_tick;
    logic [ADDR_W-1:0] i_end_addr;
    logic [ADDR_W-1:0] o_addr;
    logic              o_fetch;
    logic [3:0]        o_frac;
    logic [3:0]        o_rate;
    logic              o_fast;
    logic              o_playing;
    logic              o_done;

    modport master (
        output i_start, i_pause, i_stop, i_speed_up, i_speed_down,
               i_mode_fast, i_sample_tick, i_end_addr,
        input  o_addr, o_fetch, o_frac, o_rate, o_fast, o_playing, o_done
    );

    modport slave (
        input  i_start, i_pause, i_stop, i_speed_up, i_speed_down,
               i_mode_fast, i_sample_tick, i_end_addr,
        output o_addr, o_fetch, o_frac, o_rate, o_fast, o_playing, o_done
    );
endinterface

// File: rtl/play_rate_ctrl.sv
// Playback sequencer: play/pause/stop FSM, saturating 1..RATE_MAX rate, and one
// fetch address per sample tick (fast mode skips samples, slow mode repeats them).
module play_rate_ctrl #(
    parameter int ADDR_W   = 20,
    parameter int RATE_MAX = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    play_rate_ctrl_if.slave  bus
);
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_PLAY  = 2'd1;
    localparam logic [1:0] ST_PAUSE = 2'd2;
    localparam logic [3:0] RATE_TOP = 4'(RATE_MAX);
    localparam logic [3:0] RATE_ONE = 4'd1;

    logic [1:0]        state_q, state_d;
    logic [ADDR_W:0]   ptr_q, ptr_d;
    logic [3:0]        step_q, step_d;
    logic [3:0]        rate_q, rate_d;
    logic              fast_q, fast_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [3:0]        frac_q, frac_d;
    logic              fetch_q, fetch_d;
    logic              done_q, done_d;
    logic              playing_q, playing_d;

    logic [ADDR_W:0]   ptr_skip_s;
    logic [ADDR_W:0]   ptr_inc_s;
    logic              past_end_s;
    logic              last_rep_s;
    logic [3:0]        step_nxt_s;

    // The pointer carries one spare bit so an overshoot past the end is seen, never wrapped.
    assign ptr_skip_s = ptr_q + {{(ADDR_W-3){1'b0}}, rate_q};
    assign ptr_inc_s  = ptr_q + {{ADDR_W{1'b0}}, 1'b1};
    assign past_end_s = (ptr_q > {1'b0, bus.i_end_addr});
    assign last_rep_s = (step_q == (rate_q - 4'd1));
    assign fast_d     = bus.i_mode_fast;

    // Saturating rate update; simultaneous up/down cancel.
    always_comb begin
        rate_d = rate_q;
        if (bus.i_speed_up && !bus.i_speed_down) begin
            if (rate_q < RATE_TOP) begin
                rate_d = rate_q + 4'd1;
            end else begin
                rate_d = rate_q;
            end
        end else if (bus.i_speed_down && !bus.i_speed_up) begin
            if (rate_q > RATE_ONE) begin
                rate_d = rate_q - 4'd1;
            end else begin
                rate_d = rate_q;
            end
        end else begin
            rate_d = rate_q;
        end
    end

    // Playback FSM with stop > start > pause priority and tick handling in PLAY.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        step_nxt_s = step_q;
        addr_d     = addr_q;
        frac_d     = frac_q;
        fetch_d    = 1'b0;
        done_d     = 1'b0;
        if (bus.i_stop) begin
            state_d    = ST_IDLE;
            ptr_d      = {(ADDR_W+1){1'b0}};
            step_nxt_s = 4'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.i_start) begin
                        state_d    = ST_PLAY;
                        ptr_d      = {(ADDR_W+1){1'b0}};
                        step_nxt_s = 4'd0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_PLAY: begin
                    if (bus.i_pause) begin
                        state_d = ST_PAUSE;
                    end else if (bus.i_sample_tick) begin
                        if (past_end_s) begin
                            done_d     = 1'b1;
                            state_d    = ST_IDLE;
                            ptr_d      = {(ADDR_W+1){1'b0}};
                            step_nxt_s = 4'd0;
                        end else begin
                            fetch_d = 1'b1;
                            addr_d  = ptr_q[ADDR_W-1:0];
                            if (fast_q) begin
                                frac_d = 4'd0;
                                ptr_d  = ptr_skip_s;
                            end else begin
                                frac_d = step_q;
                                if (last_rep_s) begin
                                    step_nxt_s = 4'd0;
                                    ptr_d      = ptr_inc_s;
                                end else begin
                                    step_nxt_s = step_q + 4'd1;
                                end
                            end
                        end
                    end else begin
                        state_d = ST_PLAY;
                    end
                end
                ST_PAUSE: begin
                    if (bus.i_start) begin
                        state_d = ST_PLAY;
                    end else begin
                        state_d = ST_PAUSE;
                    end
                end
                default: begin
                    state_d    = ST_IDLE;
                    ptr_d      = {(ADDR_W+1){1'b0}};
                    step_nxt_s = 4'd0;
                end
            endcase
        end
    end

    // A rate or mode change restarts the repeat index; the pointer is untouched.
    always_comb begin
        if ((rate_d != rate_q) || (fast_d != fast_q)) begin
            step_d = 4'd0;
        end else begin
            step_d = step_nxt_s;
        end
    end

    assign playing_d = (state_d == ST_PLAY);

    // State and output registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= ST_IDLE;
            ptr_q     <= {(ADDR_W+1){1'b0}};
            step_q    <= 4'd0;
            rate_q    <= RATE_ONE;
            fast_q    <= 1'b0;
            addr_q    <= {ADDR_W{1'b0}};
            frac_q    <= 4'd0;
            fetch_q   <= 1'b0;
            done_q    <= 1'b0;
            playing_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            step_q    <= step_d;
            rate_q    <= rate_d;
            fast_q    <= fast_d;
            addr_q    <= addr_d;
            frac_q    <= frac_d;
            fetch_q   <= fetch_d;
            done_q    <= done_d;
            playing_q <= playing_d;
        end
    end

    assign bus.o_addr    = addr_q;
    assign bus.o_fetch   = fetch_q;
    assign bus.o_frac    = frac_q;
    assign bus.o_rate    = rate_q;
    assign bus.o_fast    = fast_q;
    assign bus.o_playing = playing_q;
    assign bus.o_done    = done_q;
endmodule

// File: tb/tb_play_rate_ctrl.sv
// Directed and randomized checks of play_rate_ctrl against a transaction-level model.
module tb_play_rate_ctrl;
    localparam int AW = 20;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    play_rate_ctrl_if #(.ADDR_W(AW)) bus ();

    play_rate_ctrl #(.ADDR_W(AW), .RATE_MAX(8)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    int tests = 0;
    int fails = 0;

    // Model: player condition, position, repeat index, rate, mode and last outputs.
    bit m_run, m_pause, m_fast, m_fetch, m_done;
    int m_ptr, m_step, m_rate, m_addr, m_frac, m_end;
    bit cur_fast;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_fetch"},   32'(bus.o_fetch),   32'(m_fetch));
        chk({tag, "_done"},    32'(bus.o_done),    32'(m_done));
        chk({tag, "_addr"},    32'(bus.o_addr),    32'(m_addr));
        chk({tag, "_frac"},    32'(bus.o_frac),    32'(m_frac));
        chk({tag, "_rate"},    32'(bus.o_rate),    32'(m_rate));
        chk({tag, "_fast"},    32'(bus.o_fast),    32'(m_fast));
        chk({tag, "_playing"}, 32'(bus.o_playing), 32'(m_run && !m_pause));
    endtask

    task automatic model_reset();
        m_run = 0; m_pause = 0; m_fast = 0; m_fetch = 0; m_done = 0;
        m_ptr = 0; m_step = 0; m_rate = 1; m_addr = 0; m_frac = 0;
    endtask

    // One clock cycle of stimulus, model prediction and output check.
    task automatic cyc(input string tag, input bit st, input bit pa, input bit sp,
                       input bit up, input bit dn, input bit tk);
        int new_rate;
        bit accepted;
        @(negedge clk);
        bus.i_start = st; bus.i_pause = pa; bus.i_stop = sp;
        bus.i_speed_up = up; bus.i_speed_down = dn; bus.i_sample_tick = tk;
        bus.i_mode_fast = cur_fast;
        bus.i_end_addr = AW'(m_end);
        m_fetch = 0; m_done = 0;
        accepted = tk && m_run && !m_pause && !sp && !pa;
        new_rate = m_rate;
        if (up && !dn) new_rate = (m_rate < 8) ? m_rate + 1 : 8;
        if (dn && !up) new_rate = (m_rate > 1) ? m_rate - 1 : 1;
        if (accepted) begin
            if (m_ptr > m_end) begin
                m_done = 1; m_run = 0; m_pause = 0; m_ptr = 0; m_step = 0;
            end else begin
                m_fetch = 1;
                m_addr  = m_ptr;
                if (m_fast) begin
                    m_frac = 0;
                    m_ptr  = m_ptr + m_rate;
                end else begin
                    m_frac = m_step;
                    m_step = m_step + 1;
                    if (m_step == m_rate) begin
                        m_step = 0;
                        m_ptr  = m_ptr + 1;
                    end
                end
            end
        end else if (sp) begin
            m_run = 0; m_pause = 0; m_ptr = 0; m_step = 0;
        end else if (st && !m_run) begin
            m_run = 1; m_pause = 0; m_ptr = 0; m_step = 0;
        end else if (st && m_pause) begin
            m_pause = 0;
        end else if (pa && m_run && !m_pause) begin
            m_pause = 1;
        end
        if (new_rate != m_rate || cur_fast != m_fast) m_step = 0;
        m_rate = new_rate;
        m_fast = cur_fast;
        @(posedge clk);
        #1;
        bus.i_start = 0; bus.i_pause = 0; bus.i_stop = 0;
        bus.i_speed_up = 0; bus.i_speed_down = 0; bus.i_sample_tick = 0;
        check_all(tag);
    endtask

    task automatic idle();                cyc("idle", 0, 0, 0, 0, 0, 0); endtask
    task automatic tick(input string t);  cyc(t, 0, 0, 0, 0, 0, 1); idle(); endtask
    task automatic start();               cyc("start", 1, 0, 0, 0, 0, 0); endtask
    task automatic pause();               cyc("pause", 0, 1, 0, 0, 0, 0); endtask
    task automatic stop();                cyc("stop", 0, 0, 1, 0, 0, 0); endtask
    task automatic up();                  cyc("up", 0, 0, 0, 1, 0, 0); endtask
    task automatic down();                cyc("down", 0, 0, 0, 0, 1, 0); endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        model_reset();
        check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        bit st, pa, sp, u, d, tk, last_tk;
        bus.i_start = 0; bus.i_pause = 0; bus.i_stop = 0; bus.i_speed_up = 0;
        bus.i_speed_down = 0; bus.i_mode_fast = 0; bus.i_sample_tick = 0;
        bus.i_end_addr = '0;
        cur_fast = 0; m_end = 0;
        model_reset();
        do_reset();

        // Fast mode, rate 3, end 10: fetches 0,3,6,9 then done.
        cur_fast = 1; m_end = 10;
        up(); up(); start();
        chk("fast_rate3", 32'(bus.o_rate), 32'd3);
        tick("f1"); tick("f2"); tick("f3"); tick("f4");
        chk("fast_last_addr", 32'(bus.o_addr), 32'd9);
        cyc("f5", 0, 0, 0, 0, 0, 1);
        chk("fast_done", 32'(bus.o_done), 32'd1);
        chk("fast_done_nofetch", 32'(bus.o_fetch), 32'd0);
        chk("fast_done_idle", 32'(bus.o_playing), 32'd0);
        idle();

        // Slow mode, rate 3, end 1: 0,0,0,1,1,1 with frac 0,1,2 then done.
        cur_fast = 0; m_end = 1;
        idle(); start();
        for (int i = 0; i < 6; i++) begin
            cyc("s_tick", 0, 0, 0, 0, 0, 1);
            chk("slow_addr", 32'(bus.o_addr), 32'(i / 3));
            chk("slow_frac", 32'(bus.o_frac), 32'(i % 3));
            idle();
        end
        cyc("s7", 0, 0, 0, 0, 0, 1);
        chk("slow_done", 32'(bus.o_done), 32'd1);
        idle();

        // Rate saturation both ways and cancelled simultaneous pulses.
        for (int i = 0; i < 10; i++) up();
        chk("rate_sat_hi", 32'(bus.o_rate), 32'd8);
        for (int i = 0; i < 10; i++) down();
        chk("rate_sat_lo", 32'(bus.o_rate), 32'd1);
        up();
        cyc("updown", 0, 0, 0, 1, 1, 0);
        chk("rate_updown", 32'(bus.o_rate), 32'd2);

        // Slow rate 2: pause after addr 4 frac 0, ticks ignored, resume gives addr 4 frac 1.
        m_end = 100;
        start();
        for (int i = 0; i < 9; i++) tick("pr");
        chk("pr_addr", 32'(bus.o_addr), 32'd4);
        chk("pr_frac", 32'(bus.o_frac), 32'd0);
        pause();
        tick("paused"); tick("paused");
        start();
        cyc("resume", 0, 0, 0, 0, 0, 1);
        chk("resume_fetch", 32'(bus.o_fetch), 32'd1);
        chk("resume_addr", 32'(bus.o_addr), 32'd4);
        chk("resume_frac", 32'(bus.o_frac), 32'd1);
        idle();

        // Stop with tick: no fetch; then start and tick from address 0.
        cyc("stop_tick", 0, 0, 1, 0, 0, 1);
        chk("stop_tick_nofetch", 32'(bus.o_fetch), 32'd0);
        chk("stop_tick_idle", 32'(bus.o_playing), 32'd0);
        idle(); start();
        cyc("first", 0, 0, 0, 0, 0, 1);
        chk("first_addr", 32'(bus.o_addr), 32'd0);
        idle();

        // Rate change 2 -> 4 while step is 1 restarts repeat index.
        chk("step_one", 32'(bus.o_frac), 32'd0);
        up(); up();
        for (int i = 0; i < 4; i++) begin
            cyc("r4", 0, 0, 0, 0, 0, 1);
            chk("r4_frac", 32'(bus.o_frac), 32'(i));
            chk("r4_addr", 32'(bus.o_addr), 32'd0);
            idle();
        end
        stop();

        // Reset mid-play at ptr 7, then restart from 0 with rate 1.
        down(); down(); down();
        cur_fast = 1; m_end = 20;
        idle(); start();
        for (int i = 0; i < 7; i++) tick("pre_rst");
        do_reset();
        cur_fast = 1;
        idle();
        chk("rst_rate", 32'(bus.o_rate), 32'd1);
        start();
        cyc("post_rst", 0, 0, 0, 0, 0, 1);
        chk("post_rst_addr", 32'(bus.o_addr), 32'd0);
        chk("post_rst_nodone", 32'(bus.o_done), 32'd0);
        idle();

        // Randomized command/tick mix against the model.
        last_tk = 0;
        for (int i = 0; i < 600; i++) begin
            if (!m_run && $urandom_range(0, 3) == 0) m_end = $urandom_range(0, 12);
            if ($urandom_range(0, 24) == 0) cur_fast = ~cur_fast;
            tk = !last_tk && ($urandom_range(0, 1) == 1);
            st = ($urandom_range(0, 7) == 0);
            pa = ($urandom_range(0, 15) == 0);
            sp = ($urandom_range(0, 39) == 0);
            u  = ($urandom_range(0, 9) == 0);
            d  = ($urandom_range(0, 9) == 0);
            cyc("rnd", st, pa, sp, u, d, tk);
            last_tk = tk;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/play_rate_ctrl.md
Name: play_rate_ctrl

Overview:
- Sequences audio playback from sample memory at a user-selected speed.
- Holds a rate of 1..8 and a fast/slow mode, and runs the play/pause/stop state machine.
- On each audio sample tick it issues one memory-fetch address. Fast mode skips samples; slow mode repeats each sample and reports a fractional step index for the interpolator.
- o_rate feeds the 7-segment rate-display decoder, which shows 1..8 and blanks any other code to 0.

Parameters:
- ADDR_W, 20, width of sample address and end address.
- RATE_MAX, 8, upper saturation bound of rate (lower bound fixed at 1).

Ports:
- i_clk  input  1  system clock
- i_rst_n  input  1  reset, asynchronous, active-low
- i_start  input  1  one-cycle pulse: start from address 0 when IDLE; resume when PAUSE
- i_pause  input  1  one-cycle pulse: PLAY -> PAUSE
- i_stop  input  1  one-cycle pulse: any state -> IDLE
- i_speed_up  input  1  one-cycle pulse: rate + 1, saturating at RATE_MAX
- i_speed_down  input  1  one-cycle pulse: rate - 1, saturating at 1
- i_mode_fast  input  1  level: 1 = fast (skip), 0 = slow (repeat)
- i_sample_tick  input  1  one-cycle pulse, once per audio sample period
- i_end_addr  input  ADDR_W  last valid sample address; stable while playing
- o_addr  output  ADDR_W  address of the current fetch; held between fetches
- o_fetch  output  1  one-cycle pulse: o_addr is valid and must be read
- o_frac  output  4  slow-mode repeat index 0..rate-1; 0 in fast mode
- o_rate  output  4  current rate 1..8, to the display decoder
- o_fast  output  1  registered copy of i_mode_fast
- o_playing  output  1  high in PLAY
- o_done  output  1  one-cycle pulse when end of data is reached

Behaviour:
- Reset (asynchronous, on i_rst_n low):
  - State IDLE; internal pointer ptr = 0; step counter = 0.
  - Outputs: o_addr = 0, o_fetch = 0, o_frac = 0, o_rate = 1, o_fast = 0, o_playing = 0, o_done = 0.
  - Asserting reset mid-play aborts at once; no o_done is generated.
- States: IDLE, PLAY, PAUSE.
  - IDLE + i_start -> PLAY, with ptr = 0 and step = 0.
  - PLAY + i_pause -> PAUSE; ptr and step are kept.
  - PAUSE + i_start -> PLAY; resumes at the kept ptr and step.
  - Any state + i_stop -> IDLE, with ptr = 0, step = 0, and o_addr held.
  - Command priority when pulses coincide: stop > start > pause. i_start in PLAY is ignored.
- Rate register:
  - Updates the cycle after a speed pulse, in every state.
  - i_speed_up and i_speed_down in the same cycle: no change.
  - Saturates; never wraps.
- Step reset: o_fast is i_mode_fast registered each cycle. Any change of rate or of o_fast clears step to 0 in the same update; ptr is kept.
- Sample tick handling:
  - A tick is acted on only in PLAY. Ticks in IDLE or PAUSE, or in the same cycle as i_stop or i_pause, are ignored.
  - On an accepted tick in cycle T:
    - If ptr > i_end_addr: no fetch. o_done = 1 in T+1; state -> IDLE; ptr = 0.
    - Otherwise: o_addr <= ptr and o_fetch = 1 in T+1.
      - Fast mode: o_frac <= 0; ptr <= ptr + rate.
      - Slow mode: o_frac <= step.
        - If step == rate - 1: step <= 0 and ptr <= ptr + 1.
        - Otherwise: step <= step + 1.
  - Rate 1 gives identical sequences in both modes.
- Latency and timing:
  - Fetch latency is exactly 1 cycle from tick.
  - o_fetch and o_done are never high together, and never high for two consecutive cycles.
- Arithmetic:
  - The ptr sum is computed at ADDR_W+1 bits, so no wrap is possible.
  - The end compare uses the full-width sum; an overshoot past i_end_addr terminates playback.
- Tick cadence: i_sample_tick pulses are at least 2 cycles apart.

Test Plan:
- Fast mode, rate 3, i_end_addr = 10, start, 5 ticks -> fetches at 0, 3, 6, 9; on the 5th tick o_done pulses, o_playing = 0, and there is no fetch.
- Slow mode, rate 3, i_end_addr = 1, start, 7 ticks:
  - Fetches at addresses 0,0,0,1,1,1 with o_frac 0,1,2,0,1,2.
  - The 7th tick gives o_done.
- Rate saturation: 10 × i_speed_up -> o_rate = 8; 10 × i_speed_down -> o_rate = 1; up and down in the same cycle -> unchanged.
- Pause and resume in slow mode, rate 2:
  - Pause after the fetch with o_addr = 4, o_frac = 0.
  - Ticks while paused produce no o_fetch.
  - On resume, the next fetch is o_addr = 4, o_frac = 1.
- Coincident commands and ticks:
  - i_stop together with a tick in PLAY -> no fetch; IDLE.
  - i_start then a tick -> first fetch at o_addr = 0.
- Reset mid-play at ptr = 7 (fast mode, rate 1, i_end_addr = 20), then release and start -> o_rate = 1, first fetch at o_addr = 0, no o_done.
- Rate change 2 -> 4 during slow playback with step = 1 -> step clears to 0; the next four fetches show o_frac 0,1,2,3 at the same address.
